// File: rtl/mem_sequencer_pkg.sv
`default_nettype none
// ============================================================================
// Module      : mem_sequencer_pkg
// Description : Shared definitions for the memory sequencer: FSM state
//               encoding, word width, wait-counter width and the default
//               transaction timeout.
// Revision    : 1.0 - initial release
// ============================================================================
package mem_sequencer_pkg;

    localparam int c_WORD_W          = 32;
    localparam int c_WAIT_W          = 8;
    localparam int c_TIMEOUT_DEFAULT = 255;

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_IFETCH = 3'd1,
        ST_EXEC   = 3'd2,
        ST_DATA   = 3'd3,
        ST_COMMIT = 3'd4,
        ST_HALT   = 3'd5
    } state_t;

    // States in which the shared memory port carries a request.
    function automatic logic is_req_state(input state_t s);
        return (s == ST_IFETCH) || (s == ST_DATA);
    endfunction

endpackage : mem_sequencer_pkg
`default_nettype wire

// File: rtl/mem_sequencer_wait_timer.sv
`default_nettype none
// ============================================================================
// Module      : wait_timer
// Description : 8-bit wait-cycle counter for one memory transaction.
//               clear   - forces the count to zero (outside request states)
//               count   - one non-acknowledged request cycle has elapsed
//               expired - the current cycle is the TIMEOUT-th wait cycle, so a
//                         missing ack in this cycle ends the transaction
// Ports       : clk, reset (sync, active-low), clear, count, expired
// Revision    : 1.0 - initial release
// ============================================================================
module wait_timer
    import mem_sequencer_pkg::*;
#(
    parameter int unsigned TIMEOUT = c_TIMEOUT_DEFAULT
) (
    input  logic clk,
    input  logic reset,
    input  logic clear,
    input  logic count,
    output logic expired
);

    // The count holds the number of wait cycles already spent, so the
    // TIMEOUT-th cycle is the one that starts with the count at TIMEOUT-1.
    localparam logic [c_WAIT_W-1:0] c_LAST = c_WAIT_W'(TIMEOUT - 1);

    logic [c_WAIT_W-1:0] r_cnt;

    always_ff @(posedge clk) begin
        if (!reset) begin
            r_cnt <= '0;
        end else if (clear) begin
            r_cnt <= '0;
        end else if (count && !expired) begin
            r_cnt <= r_cnt + 8'd1;
        end
    end

    assign expired = (r_cnt == c_LAST);

endmodule : wait_timer
`default_nettype wire

// File: rtl/mem_sequencer.sv
`default_nettype none
// ============================================================================
// Module      : mem_sequencer
// Description : Multi-cycle instruction sequencer sharing one memory port
//               between instruction fetch and load/store. Latches the fetched
//               instruction and load data, produces a one-cycle commit strobe,
//               counts retired instructions and stops on halt or bus timeout.
// Ports       : clk, reset (sync, active-low)
//               pc, dmem_addr, dmem_wdata, dmem_rd, dmem_wr, halt_req  - core
//               mem_req, mem_we, mem_addr, mem_wdata, mem_rdata, mem_ack - bus
//               instruction, data_rdata, commit, halted, bus_err, instret
// Revision    : 1.0 - initial release
// ============================================================================
module mem_sequencer
    import mem_sequencer_pkg::*;
#(
    parameter int unsigned TIMEOUT = c_TIMEOUT_DEFAULT
) (
    input  logic                clk,
    input  logic                reset,
    input  logic [c_WORD_W-1:0] pc,
    input  logic [c_WORD_W-1:0] dmem_addr,
    input  logic [c_WORD_W-1:0] dmem_wdata,
    input  logic                dmem_rd,
    input  logic                dmem_wr,
    input  logic                halt_req,
    output logic                mem_req,
    output logic                mem_we,
    output logic [c_WORD_W-1:0] mem_addr,
    output logic [c_WORD_W-1:0] mem_wdata,
    input  logic [c_WORD_W-1:0] mem_rdata,
    input  logic                mem_ack,
    output logic [c_WORD_W-1:0] instruction,
    output logic [c_WORD_W-1:0] data_rdata,
    output logic                commit,
    output logic                halted,
    output logic                bus_err,
    output logic [c_WORD_W-1:0] instret
);

    state_t              r_state;
    state_t              w_next;
    logic [c_WORD_W-1:0] r_instr;
    logic [c_WORD_W-1:0] r_drdata;
    logic [c_WORD_W-1:0] r_instret;
    logic                r_bus_err;

    logic w_in_req;
    logic w_ack;
    logic w_expired;
    logic w_timeout;

    assign w_in_req  = is_req_state(r_state);
    // An ack only counts while a request is actually on the bus.
    assign w_ack     = w_in_req & reset & mem_ack;
    // Ack in the expiring cycle wins over the timeout.
    assign w_timeout = w_in_req & ~mem_ack & w_expired;

    wait_timer #(
        .TIMEOUT (TIMEOUT)
    ) u_wait_timer (
        .clk     (clk),
        .reset   (reset),
        .clear   (~w_in_req),
        .count   (w_in_req & ~mem_ack),
        .expired (w_expired)
    );

    // ------------------------------------------------------------------
    // State register
    // ------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (!reset) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    // ------------------------------------------------------------------
    // Next state and bus/commit outputs. Request and commit are gated by
    // reset so an in-flight transfer is dropped in the reset cycle itself.
    // ------------------------------------------------------------------
    always_comb begin
        w_next    = r_state;
        mem_req   = 1'b0;
        mem_we    = 1'b0;
        mem_addr  = '0;
        mem_wdata = '0;
        commit    = 1'b0;

        case (r_state)
            ST_IDLE: begin
                w_next = ST_IFETCH;
            end
            ST_IFETCH: begin
                mem_req  = reset;
                mem_addr = pc;
                if (w_ack) begin
                    w_next = ST_EXEC;
                end else if (w_timeout) begin
                    w_next = ST_HALT;
                end
            end
            ST_EXEC: begin
                if (halt_req) begin
                    w_next = ST_HALT;
                end else if (dmem_rd || dmem_wr) begin
                    w_next = ST_DATA;
                end else begin
                    w_next = ST_COMMIT;
                end
            end
            ST_DATA: begin
                mem_req   = reset;
                mem_we    = reset & dmem_wr;
                mem_addr  = dmem_addr;
                mem_wdata = dmem_wdata;
                if (w_ack) begin
                    w_next = ST_COMMIT;
                end else if (w_timeout) begin
                    w_next = ST_HALT;
                end
            end
            ST_COMMIT: begin
                commit = reset;
                w_next = ST_IFETCH;
            end
            ST_HALT: begin
                w_next = ST_HALT;
            end
            default: begin
                w_next = ST_IDLE;
            end
        endcase
    end

    // ------------------------------------------------------------------
    // Latched instruction/load data, retire counter and sticky bus error
    // ------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (!reset) begin
            r_instr   <= '0;
            r_drdata  <= '0;
            r_instret <= '0;
            r_bus_err <= 1'b0;
        end else begin
            if ((r_state == ST_IFETCH) && w_ack) begin
                r_instr <= mem_rdata;
            end
            // dmem_wr wins over dmem_rd, so only pure loads update the data.
            if ((r_state == ST_DATA) && w_ack && !dmem_wr) begin
                r_drdata <= mem_rdata;
            end
            if (r_state == ST_COMMIT) begin
                r_instret <= r_instret + 32'd1;
            end
            if (w_timeout) begin
                r_bus_err <= 1'b1;
            end
        end
    end

    assign instruction = r_instr;
    assign data_rdata  = r_drdata;
    assign instret     = r_instret;
    assign bus_err     = r_bus_err;
    assign halted      = (r_state == ST_HALT);

endmodule : mem_sequencer
`default_nettype wire

// File: doc/mem_sequencer.md
MEM_SEQUENCER -- requirements
Module: mem_sequencer

Interface
REQ-001 Parameter TIMEOUT, default 255: maximum wait cycles per memory transaction before a bus error (range 1..255).
REQ-002 Port clk, input, 1: single clock; all state updates on the rising edge.
REQ-003 Port reset, input, 1: synchronous, active-low reset.
REQ-004 Port pc, input, 32: fetch address from the fetch stage.
REQ-005 Port dmem_addr / dmem_wdata, input, 32 each: data address and store data from the datapath.
REQ-006 Port dmem_rd / dmem_wr, input, 1 each: the decoded instruction is a load / store; both high is a store.
REQ-007 Port halt_req, input, 1: the decoded instruction is a halt/trap.
REQ-008 Port mem_req / mem_we, output, 1 each: shared memory request and write select.
REQ-009 Port mem_addr / mem_wdata, output, 32 each: shared memory address and write data.
REQ-010 Port mem_rdata, input, 32 and mem_ack, input, 1: memory read data and transfer-complete strobe.
REQ-011 Port instruction, output, 32: latched instruction word presented to control and datapath.
REQ-012 Port data_rdata, output, 32: latched load data presented to write-back.
REQ-013 Port commit, output, 1: one-cycle enable for the PC and register-file writes.
REQ-014 Port halted / bus_err, output, 1 each: sequencer stopped / stopped on timeout (bus_err is sticky).
REQ-015 Port instret, output, 32: retired-instruction counter.

Function
REQ-016 The FSM SHALL have states IDLE, IFETCH, EXEC, DATA, COMMIT and HALT.
REQ-017 Transitions SHALL be:
- IDLE->IFETCH unconditionally.
- IFETCH->EXEC on mem_ack.
- EXEC->HALT if halt_req; else EXEC->DATA if dmem_rd|dmem_wr; else EXEC->COMMIT.
- DATA->COMMIT on mem_ack.
- COMMIT->IFETCH.
- HALT is absorbing until reset.
REQ-018 In IFETCH the block SHALL drive mem_req=1, mem_we=0, mem_addr=pc and mem_wdata=0.
REQ-019 In DATA the block SHALL drive mem_req=1, mem_we=dmem_wr, mem_addr=dmem_addr and mem_wdata=dmem_wdata.
REQ-020 In all other states the block SHALL drive mem_req=0, mem_we=0, mem_addr=0 and mem_wdata=0.
REQ-021 Request outputs SHALL be held stable from mem_req rise until the ack cycle, inclusive.
REQ-022 mem_ack SHALL be honoured only while mem_req=1; an ack in the same cycle that mem_req rises completes the transfer (zero-wait); an ack with mem_req=0 SHALL be ignored.
REQ-023 instruction SHALL load mem_rdata on the clock edge of the IFETCH ack and hold it until the next IFETCH ack.
REQ-024 data_rdata SHALL load mem_rdata on the clock edge of a DATA ack with mem_we=0; stores SHALL leave data_rdata unchanged.
REQ-025 commit SHALL equal 1 exactly in COMMIT, and instret SHALL increment by 1 (wrapping 0xFFFFFFFF->0) on each COMMIT cycle.
REQ-026 Minimum latency SHALL be 3 cycles per non-memory instruction (IFETCH, EXEC, COMMIT) and 4 per load/store, plus memory wait cycles.
REQ-027 An 8-bit wait counter SHALL clear on entry to IFETCH or DATA and increment each non-ack cycle in those states.
REQ-028 If the wait counter reaches TIMEOUT without an ack, the FSM SHALL go to HALT, set bus_err=1 and drop mem_req the next cycle.
REQ-029 If an ack arrives in the cycle the count reaches TIMEOUT, the ack SHALL win.
REQ-030 halted SHALL equal 1 exactly in HALT; in HALT no request is issued and no commit occurs.

Reset
REQ-031 While reset=0 at a clock edge, the block SHALL set state=IDLE, instruction=0, data_rdata=0, instret=0, bus_err=0 and wait counter=0.
REQ-032 mem_req, mem_we and commit SHALL be 0 combinationally whenever reset=0, so an in-flight transaction is abandoned in that cycle.
REQ-033 The first fetch request SHALL appear in the second cycle after reset returns to 1.

Structure
REQ-034 A shared package SHALL hold the state encoding constants, the default TIMEOUT value and the 32-bit word width.
REQ-035 The wait counter SHALL be a sub-module named wait_timer (inputs clear, count; output expired).

Verification
REQ-036 Zero-wait ALU instruction: mem_ack tied to 1, pc=0x100, mem_rdata=0x00221820, no dmem_rd/wr -> request with addr 0x100; instruction=0x00221820; commit two cycles after the ack cycle; instret=1.
REQ-037 Load with 2 wait states: dmem_rd=1, dmem_addr=0x2000, ack on the 3rd DATA cycle with rdata=0xDEADBEEF -> mem_addr held at 0x2000 for 3 cycles; data_rdata=0xDEADBEEF; single commit.
REQ-038 Store: dmem_wr=1, dmem_addr=0x40, dmem_wdata=0x12345678 -> mem_we=1 with those values until ack; data_rdata unchanged.
REQ-039 Timeout: TIMEOUT=4 and no ack on fetch -> after 4 request cycles, halted=1, bus_err=1, mem_req=0; state is held until reset.
REQ-040 Reset mid-DATA: reset=0 during wait -> mem_req=0 in the same cycle; all registers cleared; fetch of pc re-issued 2 cycles after release.
REQ-041 Stray ack plus halt: mem_ack=1 while in COMMIT is ignored; a halt_req instruction -> HALT with no commit and instret unchanged.
